// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Optional RESP watchdog: define MEM_ARB_TIMEOUT_EN.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_ERR
  } state_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_D
  } owner_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-outstanding memory bus: req/gnt request phase, rvalid response.
// Master drives the request fields, slave returns gnt/rvalid/rdata.
interface mem_port_arbiter_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_lane_align.sv
// Byte-lane alignment: store strobes/replication, load extract/extend,
// and misalignment detection for RV32 b/h/w accesses.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_ofs,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] sh;
  logic        sgn;

  always_comb begin
    be         = 4'hF;
    wdata_lane = wdata;
    misaligned = 1'b0;
    unique case (1'b1)
      size == SZ_B: begin
        be         = 4'b0001 << ofs;
        wdata_lane = {4{wdata[7:0]}};
      end
      size == SZ_H: begin
        be         = 4'b0011 << ofs;
        wdata_lane = {2{wdata[15:0]}};
        misaligned = ofs[0];
      end
      default: misaligned = ofs != 2'b00;
    endcase
  end

  // Words are always aligned here, so sh equals rdata for them.
  always_comb begin
    sh        = rdata >> {ld_ofs, 3'b000};
    sgn       = !ld_funct3[2];
    rdata_ext = sh;
    unique case (1'b1)
      ld_funct3[1:0] == SZ_B:
        rdata_ext = {{24{sgn & sh[7]}}, sh[7:0]};
      ld_funct3[1:0] == SZ_H:
        rdata_ext = {{16{sgn & sh[15]}}, sh[15:0]};
      default: rdata_ext = sh;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and memory stage (D).
// Optional RESP watchdog enabled by MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  mem_port_arbiter_if.master mem
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [31:0] WMASK = 32'hFFFF_FFFC;

  state_t      state, state_nx;
  owner_t      owner;
  logic [3:0]  streak;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_ofs;
  logic        idle, grant_d, grant_if;
  logic        owner_req, done, timeout;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, rdata_ext;
  logic        mis;

  assign idle      = state == S_IDLE;
  assign grant_d   = idle && d_req &&
                     !(if_req && streak == STREAK_MAX);
  assign grant_if  = idle && if_req && !grant_d;
  assign owner_req = (owner == OWNER_D) ? d_req : if_req;
  assign done      = state == S_RESP &&
                     (mem.rvalid || timeout);

  mem_lane_align u_align (
    .size       (d_funct3[1:0]),
    .ofs        (d_addr[1:0]),
    .wdata      (d_wdata),
    .be         (be_c),
    .wdata_lane (wdata_c),
    .misaligned (mis),
    .ld_funct3  (ld_funct3),
    .ld_ofs     (ld_ofs),
    .rdata      (mem.rdata),
    .rdata_ext  (rdata_ext)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               cnt <= '0;
    else if (state != S_RESP) cnt <= '0;
    else if (!mem.rvalid)     cnt <= cnt + 16'd1;
  end

  assign timeout = state == S_RESP && !mem.rvalid &&
                   cnt == TO_LAST;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (grant_d)       state_nx = mis ? S_ERR : S_REQ;
        else if (grant_if) state_nx = S_REQ;
      end
      S_REQ: begin
        if (!owner_req)   state_nx = S_IDLE;
        else if (mem.gnt) state_nx = S_RESP;
      end
      S_RESP: if (done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    if_ready = 1'b0;
    d_ready  = 1'b0;
    d_err    = 1'b0;
    unique case (1'b1)
      done && owner == OWNER_D: begin
        d_ready = d_req;
        d_err   = d_req && timeout;
      end
      done && owner == OWNER_IF: if_ready = if_req;
      state == S_ERR: begin
        d_ready = d_req;
        d_err   = d_req;
      end
      default: ;
    endcase
    if_rdata = '0;
    if (if_ready) if_rdata = timeout ? NOP : mem.rdata;
    d_rdata = (d_ready && !d_err) ? rdata_ext : '0;
  end

  assign mem.req   = state == S_REQ && owner_req;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.be    = be_q;
  assign mem.wdata = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWNER_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      ld_funct3 <= '0;
      ld_ofs    <= '0;
    end else if (grant_d) begin
      owner     <= OWNER_D;
      we_q      <= d_we;
      addr_q    <= d_addr & WMASK;
      be_q      <= be_c;
      wdata_q   <= wdata_c;
      ld_funct3 <= d_funct3;
      ld_ofs    <= d_addr[1:0];
    end else if (grant_if) begin
      owner     <= OWNER_IF;
      we_q      <= 1'b0;
      addr_q    <= if_addr & WMASK;
      be_q      <= 4'hF;
      wdata_q   <= '0;
    end
  end

  // Streak only advances on D grants that jump a waiting fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        streak <= '0;
    else if (!if_req)  streak <= '0;
    else if (grant_if) streak <= '0;
    else if (grant_d && streak != STREAK_MAX)
      streak <= streak + 4'd1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, lanes, flush,
// misalignment, async reset and (with MEM_ARB_TIMEOUT_EN) timeout.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk, reset;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ready, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_funct3;
  logic        auto_mem, m_gnt, m_rv, rv_q;
  logic [31:0] rd_word;
  int          total, bad;

  mem_port_arbiter_if mem_bus ();

  assign mem_bus.gnt    = auto_mem ? mem_bus.req : m_gnt;
  assign mem_bus.rvalid = auto_mem ? rv_q : m_rv;
  assign mem_bus.rdata  = rd_word;

  always @(posedge clk) rv_q <= mem_bus.req && mem_bus.gnt;

  mem_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_funct3 (d_funct3),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .d_err    (d_err),
    .mem      (mem_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic d_txn(input string tag, input logic w,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rw,
                       input logic [3:0] xbe, input logic [31:0] xwd,
                       input logic [31:0] xrd);
    d_req = 1'b1; d_we = w; d_funct3 = f3;
    d_addr = a; d_wdata = wd; rd_word = rw;
    tick();
    chk({tag, ".req"}, 32'(mem_bus.req), 32'd1);
    chk({tag, ".we"}, 32'(mem_bus.we), 32'(w));
    chk({tag, ".addr"}, mem_bus.addr, a & 32'hFFFF_FFFC);
    chk({tag, ".be"}, 32'(mem_bus.be), 32'(xbe));
    chk({tag, ".wdata"}, mem_bus.wdata, xwd);
    tick();
    chk({tag, ".ready"}, 32'({d_ready, d_err}), 32'd2);
    chk({tag, ".rdata"}, d_rdata, xrd);
    d_req = 1'b0;
    tick();
  endtask

  task automatic misal(input string tag, input logic [2:0] f3,
                       input logic [31:0] a);
    d_req = 1'b1; d_we = 1'b0; d_funct3 = f3; d_addr = a;
    tick();
    chk({tag, ".req"}, 32'(mem_bus.req), 32'd0);
    chk({tag, ".rdy_err"}, 32'({d_ready, d_err}), 32'd3);
    chk({tag, ".rdata"}, d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    chk({tag, ".after"}, 32'({mem_bus.req, d_ready}), 32'd0);
  endtask

  initial begin
    int  w;
    bit  is_if;
    int  n;
    total = 0; bad = 0;
    reset = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_funct3 = '0; d_wdata = '0;
    auto_mem = 1'b0; m_gnt = 1'b0; m_rv = 1'b0;
    rd_word = '0;

    #3;
    chk("rst.ready", 32'({if_ready, d_ready, d_err}), 32'd0);
    chk("rst.memreq", 32'(mem_bus.req), 32'd0);
    chk("rst.addr", mem_bus.addr, 32'd0);
    chk("rst.be", 32'(mem_bus.be), 32'd0);
    chk("rst.rdata", if_rdata | d_rdata, 32'd0);
    #9 reset = 1'b1;

    // IF only, zero-wait memory
    tick();
    auto_mem = 1'b1; rd_word = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("if.c0.req", 32'(mem_bus.req), 32'd0);
    tick();
    chk("if.c1.req", 32'(mem_bus.req), 32'd1);
    chk("if.c1.addr", mem_bus.addr, 32'h100);
    chk("if.c1.be_we", 32'({mem_bus.be, mem_bus.we}), 32'h1E);
    chk("if.c1.ready", 32'(if_ready), 32'd0);
    tick();
    chk("if.c2.ready", 32'(if_ready), 32'd1);
    chk("if.c2.rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 1'b0;
    tick();
    chk("if.c3.ready", 32'(if_ready), 32'd0);

    // both held: D,D,D,D,IF repeating
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_W;
    d_addr = 32'h200; rd_word = 32'hCAFE_F00D;
    for (int k = 0; k < 10; k++) begin
      w = 0;
      is_if = (k % 5) == 4;
      do begin
        tick();
        w++;
      end while (!mem_bus.req && w < 8);
      chk($sformatf("arb%0d.addr", k), mem_bus.addr,
          is_if ? 32'h100 : 32'h200);
      tick();
      chk($sformatf("arb%0d.rdy", k), 32'({if_ready, d_ready}),
          is_if ? 32'd2 : 32'd1);
      if (k == 0)
        chk("arb0.rdata", d_rdata, 32'hCAFE_F00D);
      if (k == 9) begin
        if_req = 1'b0;
        d_req = 1'b0;
      end
      tick();
    end

    // lane alignment
    d_txn("sb", 1'b1, F3_B, 32'h203, 32'h1234_56A5, 32'h0,
          4'b1000, 32'hA5A5_A5A5, 32'h0);
    d_txn("sh", 1'b1, F3_H, 32'h202, 32'h0000_BEEF, 32'h0,
          4'b1100, 32'hBEEF_BEEF, 32'h0);
    d_txn("lh", 1'b0, F3_H, 32'h202, 32'h0, 32'h8001_0000,
          4'b1100, 32'h0, 32'hFFFF_8001);
    d_txn("lhu", 1'b0, F3_HU, 32'h202, 32'h0, 32'h8001_0000,
          4'b1100, 32'h0, 32'h0000_8001);
    d_txn("lb", 1'b0, F3_B, 32'h203, 32'h0, 32'h8001_0000,
          4'b1000, 32'h0, 32'hFFFF_FF80);
    d_txn("lbu", 1'b0, F3_BU, 32'h201, 32'h0, 32'h1234_5678,
          4'b0010, 32'h0, 32'h0000_0056);
    d_txn("lw", 1'b0, F3_W, 32'h204, 32'h0, 32'h1122_3344,
          4'b1111, 32'h0, 32'h1122_3344);

    misal("mis_lw", F3_W, 32'h201);
    misal("mis_lh", F3_H, 32'h203);

    // IF dropped after gnt; rvalid 3 cycles later is discarded
    auto_mem = 1'b0;
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    chk("fl.req", 32'(mem_bus.req), 32'd1);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = F3_W;
    d_addr = 32'h204; rd_word = 32'h5555_AAAA;
    tick();
    tick();
    chk("fl.wait", 32'({mem_bus.req, d_ready, if_ready}), 32'd0);
    m_rv = 1'b1;
    #1 chk("fl.discard", 32'({if_ready, d_ready}), 32'd0);
    tick();
    m_rv = 1'b0;
    chk("fl.idle", 32'({mem_bus.req, d_ready}), 32'd0);
    tick();
    chk("fl.d.req", 32'(mem_bus.req), 32'd1);
    chk("fl.d.addr", mem_bus.addr, 32'h204);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; m_rv = 1'b1;
    #1 chk("fl.d.ready", 32'(d_ready), 32'd1);
    chk("fl.d.rdata", d_rdata, 32'h5555_AAAA);
    d_req = 1'b0;
    tick();
    m_rv = 1'b0;

    // async reset in RESP
    d_req = 1'b1; d_addr = 32'h208;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    #2 reset = 1'b0;
    #1 chk("ar.addr", mem_bus.addr, 32'd0);
    chk("ar.be_we", 32'({mem_bus.be, mem_bus.we}), 32'd0);
    m_rv = 1'b1;
    #1 chk("ar.ready", 32'({d_ready, d_err, if_ready}), 32'd0);
    d_req = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    chk("ar.late_rv", 32'({d_ready, if_ready}), 32'd0);
    m_rv = 1'b0;
    tick();
    chk("ar.no_req", 32'(mem_bus.req), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    d_req = 1'b1; d_funct3 = F3_W; d_addr = 32'h20C;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    n = 0;
    while (!d_ready && n < 400) begin
      tick();
      n++;
    end
    chk("to.cycles", 32'(n), 32'd254);
    chk("to.err", 32'(d_err), 32'd1);
    chk("to.rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
`else
    n = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
